load_store_unit: RTL and testbench

//  Data-memory access unit for the CPU load/store path. Accepts one load/store per instruction

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store access unit: one req/ack data-memory transaction per instruction.
// It stalls the CPU while the access is in flight and returns the aligned, extended load word.
module load_store_unit #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sign_ext,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_rdata,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t          r_state, w_state_next;
   logic [TO_W-1:0] r_cnt;
   logic [TO_W-1:0] w_cnt_inc;
   logic [1:0]      r_size, r_lane;
   logic            r_sign;
   logic            r_done, r_err, r_mem_req, r_mem_we;
   logic [31:0]     r_rdata, r_mem_addr, r_mem_wdata;
   logic [3:0]      r_mem_be;
   logic            w_misaligned, w_ack, w_timeout;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata, w_load;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;

   assign w_cnt_inc = r_cnt + TO_W'(1);
   assign w_ack     = (r_state == S_ACCESS) && i_mem_ack;
   // Ack on the abort cycle wins, so the timeout only counts when ack is absent.
   assign w_timeout = (r_state == S_ACCESS) && !i_mem_ack && (w_cnt_inc == TO_W'(TIMEOUT));

   always_comb begin
      w_misaligned = 1'b0;
      w_be         = 4'b1111;
      w_wdata      = i_wdata;
      case (i_size)
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_misaligned = i_addr[0];
            w_be         = 4'b0011 << {i_addr[1], 1'b0};
            w_wdata      = {2{i_wdata[15:0]}};
         end
         default: w_misaligned = (i_addr[1:0] != 2'b00);
      endcase
   end

   // Lane extraction uses the size/offset captured when the access started.
   always_comb begin
      w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
      w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (r_size)
         2'b00:   w_load = {{24{r_sign & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_sign & w_half[15]}}, w_half};
         default: w_load = i_mem_rdata;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (i_req) w_state_next = w_misaligned ? S_DONE : S_ACCESS;
         S_ACCESS: if (w_ack || w_timeout) w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_next;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt       <= '0;
         r_size      <= 2'b00;
         r_lane      <= 2'b00;
         r_sign      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req && w_misaligned) begin
                  r_done <= 1'b1;
                  r_err  <= 1'b1;
               end else if (i_req) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= i_we;
                  r_mem_addr  <= {i_addr[31:2], 2'b00};
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
                  r_cnt       <= '0;
                  r_size      <= i_size;
                  r_lane      <= i_addr[1:0];
                  r_sign      <= i_sign_ext;
               end
            end
            S_ACCESS: begin
               if (w_ack) begin
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  if (!r_mem_we) r_rdata <= w_load;
               end else if (w_timeout) begin
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_stall     = ((r_state == S_IDLE) && i_req) || (r_state == S_ACCESS);
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_rdata     = r_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of loads/stores plus
// hand-written sequences for idle acks and reset during an access.
module tb_load_store_unit;

   logic        clk, reset_n;
   logic        req, we, sign_ext, mem_ack;
   logic [1:0]  size;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int total = 0;
   int bad   = 0;

   load_store_unit #(.TIMEOUT(16), .TO_W(5)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_we(we), .i_size(size),
      .i_sign_ext(sign_ext), .i_addr(addr), .i_wdata(wdata),
      .o_stall(stall), .o_done(done), .o_err(err), .o_rdata(rdata),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
      .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] mrd;
      int          ack_at;   // ACCESS cycle carrying ack (0 = never)
      int          lat;      // cycles from req seen in IDLE to done
      int          reqcyc;   // cycles with mem_req high
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] mwd;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic w, logic [1:0] sz, logic sx, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] mrd, int ack_at, int lat,
                               int rc, logic e, logic [31:0] rd, logic [3:0] be,
                               logic [31:0] mwd);
      vec_t v;
      v.we = w; v.size = sz; v.sx = sx; v.addr = a; v.wd = wd; v.mrd = mrd;
      v.ack_at = ack_at; v.lat = lat; v.reqcyc = rc; v.err = e; v.rdata = rd;
      v.be = be; v.mwd = mwd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int          cyc, acc, lat;
      logic        done_seen, stall_ok;
      logic [31:0] c_addr, c_wd;
      logic [3:0]  c_be;
      logic        c_we;
      cyc = 0; acc = 0; lat = -1; done_seen = 1'b0; stall_ok = 1'b1;
      c_addr = '0; c_wd = '0; c_be = '0; c_we = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wd;
      while (!done_seen && cyc < 40) begin
         @(negedge clk);
         if (done) begin
            done_seen = 1'b1;
            lat = cyc;
            if (stall !== 1'b0) stall_ok = 1'b0;
            chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, v.err});
            chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
         end else begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (mem_req) begin
               acc++;
               if (acc == 1) begin
                  c_addr = mem_addr; c_be = mem_be; c_wd = mem_wdata; c_we = mem_we;
               end
               mem_ack   = (acc == v.ack_at);
               mem_rdata = v.mrd;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
         end
      end
      if (!done_seen) begin
         total++; bad++;
         $display("FAIL v%0d done_wait: no done within 40 cycles", idx);
      end
      chk($sformatf("v%0d latency", idx), lat, v.lat);
      chk($sformatf("v%0d mem_req_cycles", idx), acc, v.reqcyc);
      chk($sformatf("v%0d stall", idx), {31'b0, stall_ok}, 32'd1);
      if (v.reqcyc > 0) begin
         chk($sformatf("v%0d mem_addr", idx), c_addr, {v.addr[31:2], 2'b00});
         chk($sformatf("v%0d mem_be", idx), {28'b0, c_be}, {28'b0, v.be});
         chk($sformatf("v%0d mem_we", idx), {31'b0, c_we}, {31'b0, v.we});
         if (v.we) chk($sformatf("v%0d mem_wdata", idx), c_wd, v.mwd);
      end
      @(posedge clk); #1;
      req = 1'b0;
      $display("txn %0d: we=%0b size=%0d addr=%h lat=%0d err=%0b rdata=%h",
               idx, v.we, v.size, v.addr, lat, err, rdata);
   endtask

   initial begin
      vec_t rv;
      //                 we    size  sx    addr          wdata         mem_rdata    ack lat rc err   rdata         be       mwd
      vecs[0]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1,  2,  1, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
      vecs[1]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,        32'hBEEF_0001, 1,  2,  1, 1'b0, 32'h0000_BEEF, 4'b1100, 32'h0);
      vecs[2]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0,        3,  4,  3, 1'b0, 32'h0000_BEEF, 4'b0010, 32'hABAB_ABAB);
      vecs[3]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0,        32'h0,         1,  1,  0, 1'b1, 32'h0000_BEEF, 4'b0000, 32'h0);
      vecs[4]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_5001, 32'h0,        32'h1234_5678, 2,  3,  2, 1'b0, 32'h0000_0056, 4'b0010, 32'h0);
      vecs[5]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0,        32'h1234_8001, 1,  2,  1, 1'b0, 32'hFFFF_8001, 4'b0011, 32'h0);
      vecs[6]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'h0,        32'hDEAD_BEEF, 1,  2,  1, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      vecs[7]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_8002, 32'h1234_CAFE, 32'h0,        1,  2,  1, 1'b0, 32'hDEAD_BEEF, 4'b1100, 32'hCAFE_CAFE);
      vecs[8]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'h0102_0304, 32'h0,        2,  3,  2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0102_0304);
      vecs[9]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_8001, 32'h0,        32'h0,         1,  1,  0, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0);
      vecs[10] = mk(1'b0, 2'd3, 1'b1, 32'h0000_A008, 32'h0,        32'h55AA_55AA, 1,  2,  1, 1'b0, 32'h55AA_55AA, 4'b1111, 32'h0);
      vecs[11] = mk(1'b0, 2'd2, 1'b0, 32'h0000_B000, 32'h0,        32'h1111_1111, 0,  17, 16, 1'b1, 32'h0,        4'b1111, 32'h0);
      vecs[12] = mk(1'b0, 2'd2, 1'b0, 32'h0000_C000, 32'h0,        32'h0BAD_F00D, 16, 17, 16, 1'b0, 32'h0BAD_F00D, 4'b1111, 32'h0);
      vecs[13] = mk(1'b0, 2'd0, 1'b1, 32'h0000_D002, 32'h0,        32'h007F_0000, 1,  2,  1, 1'b0, 32'h0000_007F, 4'b0100, 32'h0);

      reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset mem_req", {31'b0, mem_req}, 32'd0);
      chk("reset done",    {31'b0, done},    32'd0);
      chk("reset err",     {31'b0, err},     32'd0);
      chk("reset rdata",   rdata,            32'd0);
      chk("reset stall",   {31'b0, stall},   32'd0);
      chk("reset mem_be",  {28'b0, mem_be},  32'd0);

      // Acks while idle must not produce a completion.
      mem_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ack done",  {31'b0, done},  32'd0);
         chk("idle_ack stall", {31'b0, stall}, 32'd0);
      end
      @(posedge clk); #1 mem_ack = 1'b0;

      for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);

      // Reset in the middle of an access with no ack.
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h0000_E000;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst mem_req_before", {31'b0, mem_req}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst mem_req", {31'b0, mem_req}, 32'd0);
      chk("midrst done",    {31'b0, done},    32'd0);
      chk("midrst err",     {31'b0, err},     32'd0);
      chk("midrst rdata",   rdata,            32'd0);
      req = 1'b0;
      @(posedge clk); #1;
      chk("midrst stall", {31'b0, stall}, 32'd0);
      reset_n = 1'b1;
      $display("txn reset: mid-access reset applied and released");

      rv = mk(1'b0, 2'd2, 1'b0, 32'h0000_F00C, 32'h0, 32'h1357_9BDF, 1, 2, 1, 1'b0,
              32'h1357_9BDF, 4'b1111, 32'h0);
      run_txn(14, rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
